// File: rtl/oam_dma_pkg.sv
// Shared CPU-subsystem definitions used by the sprite DMA engine.
package oam_dma_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHalt,
    StAlign,
    StRead,
    StWrite
  } oam_dma_state_t;

  localparam logic [15:0] OAM_DMA_ADDR = 16'h4014;
  localparam int unsigned XFER_LEN     = 256;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: on a CPU store to the trigger address, halts the CPU and copies one 256-byte
// CPU page into PPU OAM as alternating get/put bus cycles, advancing only on cpu_en.
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter logic [15:0] TRIGGER_ADDR = OAM_DMA_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_en,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_write,
  input  logic [7:0]  bus_rdata,
  output logic        cpu_halt,
  output logic [15:0] bus_addr,
  output logic        bus_read,
  output logic [7:0]  oam_wdata,
  output logic        oam_we,
  output logic        busy
);

  oam_dma_state_t state_q, state_d;
  logic [7:0]     page_q, page_d;
  logic [7:0]     idx_q, idx_d;
  logic [7:0]     data_q, data_d;
  logic           parity_q, parity_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      page_q   <= 8'h00;
      idx_q    <= 8'h00;
      data_q   <= 8'h00;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      parity_q <= parity_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    idx_d     = idx_q;
    data_d    = data_q;
    // Free-running get/put phase: 0 = get (read) cycle, 1 = put (write) cycle.
    parity_d  = parity_q ^ cpu_en;
    bus_read  = 1'b0;
    bus_addr  = 16'h0000;
    oam_we    = 1'b0;
    oam_wdata = 8'h00;

    unique case (state_q)
      StIdle: begin
        if (cpu_en && cpu_write && (cpu_addr == TRIGGER_ADDR)) begin
          page_d  = cpu_wdata;
          idx_d   = 8'h00;
          state_d = StHalt;
        end
      end
      StHalt: begin
        // Reads must land on get cycles; insert ALIGN when the next cycle would be a put.
        if (cpu_en) state_d = parity_q ? StRead : StAlign;
      end
      StAlign: begin
        if (cpu_en) state_d = StRead;
      end
      StRead: begin
        bus_read = 1'b1;
        bus_addr = {page_q, idx_q};
        if (cpu_en) begin
          data_d  = bus_rdata;
          state_d = StWrite;
        end
      end
      StWrite: begin
        oam_wdata = data_q;
        oam_we    = cpu_en;
        if (cpu_en) begin
          if (idx_q == 8'hFF) begin
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = StRead;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy     = (state_q != StIdle);
  assign cpu_halt = busy;

endmodule
